// File: rtl/calc_alu_seq_if.sv
// Operation/result handshake bundle for the calculator execution core.
// The master drives operations and accepts results; the slave is the core.
interface calc_alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             flag_ovf;
  logic             flag_dbz;
  logic             flag_ill;

  modport master (
    output op_valid, opcode, operand_a, operand_b, res_ready,
    input  op_ready, res_valid, result, flag_ovf, flag_dbz, flag_ill
  );

  modport slave (
    input  op_valid, opcode, operand_a, operand_b, res_ready,
    output op_ready, res_valid, result, flag_ovf, flag_dbz, flag_ill
  );
endinterface

// File: rtl/calc_alu_seq.sv
// Calculator execution core: one operation per op handshake, one result per
// res handshake. ADD/SUB/illegal/divide-by-zero finish at the accept edge;
// MUL (shift-add) and DIV/MOD (restoring) iterate one bit per cycle.
// Optional feature macro: CALC_MOD_EN -- when defined, opcode 100 is MOD;
// when undefined, opcode 100 is reported as illegal and no remainder path exists.
module calc_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  calc_alu_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_op_ready;
  logic             r_res_valid;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  // High half: MUL partial product / DIV partial remainder.
  // Low half: MUL multiplier bits / DIV dividend bits shifting into quotient.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf;
  logic             r_dbz;
  logic             r_ill;

  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_q_result;
  logic             w_q_ovf;
  logic             w_q_dbz;
  logic             w_q_ill;
  logic             w_go_exec;

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH-1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_div_nxt;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   w_fin_result;
  logic               w_fin_ovf;

  assign w_accept = bus.op_valid & r_op_ready;

  // Decode the request at the accept edge: single-cycle results or hand-off to EXEC.
  always_comb begin
    w_sum      = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
    w_q_result = '0;
    w_q_ovf    = 1'b0;
    w_q_dbz    = 1'b0;
    w_q_ill    = 1'b0;
    w_go_exec  = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        w_q_result = w_sum[WIDTH-1:0];
        w_q_ovf    = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_q_result = bus.operand_a - bus.operand_b;
        w_q_ovf    = (bus.operand_a < bus.operand_b);
      end
      OP_MUL: begin
        w_go_exec = 1'b1;
      end
      OP_DIV: begin
        if (bus.operand_b == '0) begin
          w_q_result = {WIDTH{1'b1}};
          w_q_dbz    = 1'b1;
        end else begin
          w_go_exec = 1'b1;
        end
      end
`ifdef CALC_MOD_EN
      OP_MOD: begin
        if (bus.operand_b == '0) begin
          w_q_result = bus.operand_a;
          w_q_dbz    = 1'b1;
        end else begin
          w_go_exec = 1'b1;
        end
      end
`else
      OP_MOD: begin
        w_q_ill = 1'b1;
      end
`endif
      default: begin
        w_q_ill = 1'b1;
      end
    endcase
  end

  // One iteration of shift-add multiply or restoring divide on the accumulator.
  always_comb begin
    if (r_acc[0]) begin
      w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
    end else begin
      w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    end
    w_mul_nxt   = {w_mul_sum, r_acc[WIDTH-1:1]};
    w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    w_div_diff  = w_div_shift[WIDTH-1:0] - r_b;
    if (w_div_shift >= {1'b0, r_b}) begin
      w_div_nxt = {w_div_diff, r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_div_nxt = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
    if (r_op == OP_MUL) begin
      w_acc_nxt = w_mul_nxt;
    end else begin
      w_acc_nxt = w_div_nxt;
    end
  end

  // Select the iterative result from the accumulator after the last iteration.
  always_comb begin
    w_fin_result = '0;
    w_fin_ovf    = 1'b0;
    case (r_op)
      OP_MUL: begin
        w_fin_result = w_acc_nxt[WIDTH-1:0];
        w_fin_ovf    = |w_acc_nxt[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        w_fin_result = w_acc_nxt[WIDTH-1:0];
      end
`ifdef CALC_MOD_EN
      OP_MOD: begin
        w_fin_result = w_acc_nxt[2*WIDTH-1:WIDTH];
      end
`endif
      default: begin
        w_fin_result = '0;
      end
    endcase
  end

  // Next-state logic for IDLE -> (EXEC) -> DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_go_exec) begin
            w_state_nxt = S_EXEC;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register with registered handshake outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op_ready  <= 1'b1;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op_ready  <= (w_state_nxt == S_IDLE);
      r_res_valid <= (w_state_nxt == S_DONE);
    end
  end

  // Operand capture, iteration progress and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 3'b000;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_dbz    <= 1'b0;
      r_ill    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= bus.opcode;
            r_a      <= bus.operand_a;
            r_b      <= bus.operand_b;
            r_cnt    <= '0;
            if (bus.opcode == OP_MUL) begin
              r_acc <= {{WIDTH{1'b0}}, bus.operand_b};
            end else begin
              r_acc <= {{WIDTH{1'b0}}, bus.operand_a};
            end
            r_result <= w_q_result;
            r_ovf    <= w_q_ovf;
            r_dbz    <= w_q_dbz;
            r_ill    <= w_q_ill;
          end
        end
        S_EXEC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_result <= w_fin_result;
            r_ovf    <= w_fin_ovf;
            r_dbz    <= 1'b0;
            r_ill    <= 1'b0;
          end
        end
        S_DONE: begin
          r_result <= r_result;
        end
        default: begin
          r_result <= r_result;
        end
      endcase
    end
  end

  assign bus.op_ready  = r_op_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.result    = r_result;
  assign bus.flag_ovf  = r_ovf;
  assign bus.flag_dbz  = r_dbz;
  assign bus.flag_ill  = r_ill;

endmodule

// File: tb/tb_calc_alu_seq.sv
// Directed bench for calc_alu_seq (WIDTH=8). Expected results come from a
// behavioural model and are queued at issue time, popped when the result appears.
module tb_calc_alu_seq;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         dbz;
    logic         ill;
    int           lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;
  int   n_fail;
  exp_t sb[$];

  calc_alu_seq_if #(.WIDTH(W)) bus ();

  calc_alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    e.res = 8'd0; e.ovf = 1'b0; e.dbz = 1'b0; e.ill = 1'b0; e.lat = 1;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; e.res = s[W-1:0]; e.ovf = s[W]; end
      3'd1: begin e.res = a - b; e.ovf = (a < b); end
      3'd2: begin p = 16'(a) * 16'(b); e.res = p[W-1:0]; e.ovf = (p[2*W-1:W] != 8'd0); e.lat = W + 1; end
      3'd3: begin
        if (b == 8'd0) begin e.res = 8'hFF; e.dbz = 1'b1; end
        else begin e.res = a / b; e.lat = W + 1; end
      end
`ifdef CALC_MOD_EN
      3'd4: begin
        if (b == 8'd0) begin e.res = a; e.dbz = 1'b1; end
        else begin e.res = a % b; e.lat = W + 1; end
      end
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Issue one operation, check result/flags/latency, optionally hold res_ready low.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int hold);
    exp_t e;
    int   n;
    int   lat;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    bus.op_valid = 1'b1; bus.opcode = op; bus.operand_a = a; bus.operand_b = b;
    n = 0;
    while (bus.op_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0; bus.opcode = 3'b111; bus.operand_a = ~a; bus.operand_b = ~b;
    lat = 1;
    while (bus.res_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check({tag, "_lat"}, 32'(lat), 32'(e.lat));
    check({tag, "_res"}, 32'(bus.result), 32'(e.res));
    check({tag, "_ovf"}, 32'(bus.flag_ovf), 32'(e.ovf));
    check({tag, "_dbz"}, 32'(bus.flag_dbz), 32'(e.dbz));
    check({tag, "_ill"}, 32'(bus.flag_ill), 32'(e.ill));
    check({tag, "_opready_busy"}, 32'(bus.op_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.op_valid = 1'b1; bus.opcode = 3'b000; bus.operand_a = 8'd3; bus.operand_b = 8'd4;
      check({tag, "_hold_valid"}, 32'(bus.res_valid), 32'd1);
      check({tag, "_hold_res"}, 32'({bus.result, bus.flag_ovf, bus.flag_dbz, bus.flag_ill}),
            32'({e.res, e.ovf, e.dbz, e.ill}));
      check({tag, "_hold_opready"}, 32'(bus.op_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.op_valid  = 1'b0;
    check({tag, "_post_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_post_ready"}, 32'(bus.op_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic [2:0] rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    clk = 1'b0; rst_n = 1'b0;
    n_total = 0; n_pass = 0; n_fail = 0;
    bus.op_valid = 1'b0; bus.opcode = 3'b000; bus.operand_a = 8'd0; bus.operand_b = 8'd0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_opready", 32'(bus.op_ready), 32'd1);
    check("rst_resvalid", 32'(bus.res_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", 32'({bus.flag_ovf, bus.flag_dbz, bus.flag_ill}), 32'd0);
    rst_n = 1'b1;

    do_op("add_200_100", 3'd0, 8'd200, 8'd100, 0);
    do_op("sub_5_7", 3'd1, 8'd5, 8'd7, 0);
    do_op("mul_13_11", 3'd2, 8'd13, 8'd11, 0);
    do_op("mul_16_16", 3'd2, 8'd16, 8'd16, 0);
    do_op("div_100_7", 3'd3, 8'd100, 8'd7, 0);
    do_op("mod_100_7", 3'd4, 8'd100, 8'd7, 0);
    do_op("div_5_0", 3'd3, 8'd5, 8'd0, 0);
    do_op("mod_5_0", 3'd4, 8'd5, 8'd0, 0);
    do_op("op_111", 3'd7, 8'd9, 8'd9, 0);
    do_op("div_255_1", 3'd3, 8'd255, 8'd1, 0);
    do_op("div_7_200", 3'd3, 8'd7, 8'd200, 0);
    do_op("mul_255_255", 3'd2, 8'd255, 8'd255, 0);
    do_op("bp_mul_15_15", 3'd2, 8'd15, 8'd15, 5);
    do_op("add_3_4", 3'd0, 8'd3, 8'd4, 0);

    // Abort a DIV in the middle of its iterations with an asynchronous reset.
    @(negedge clk);
    bus.op_valid = 1'b1; bus.opcode = 3'd3; bus.operand_a = 8'd100; bus.operand_b = 8'd3;
    n = 0;
    while (bus.op_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    bus.op_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_valid_in_rst", 32'(bus.res_valid), 32'd0);
    check("abort_ready_in_rst", 32'(bus.op_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_valid_after", 32'(bus.res_valid), 32'd0);
    check("abort_ready_after", 32'(bus.op_ready), 32'd1);
    do_op("add_1_1", 3'd0, 8'd1, 8'd1, 0);

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 4));
      ra  = 8'($urandom_range(0, 255));
      rb  = (i == 3) ? 8'd0 : 8'($urandom_range(0, 255));
      do_op($sformatf("rnd%0d", i), rop, ra, rb, i % 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
